mux3_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit three-input datapath mux among three requesters: fetch (source 0), load/store (source 1) and debug/DMA (source 2). It grants one requester at a time and drives the mux select with the encoding `00`→IN0, `01`→IN1, `10`→IN2. The mux output is registered onto a shared result bus with a valid flag and a source tag. It bounds burst length so no requester can starve the others.

---
 rtl/mux3_rr_arbiter_pkg.sv | 30 +++
 rtl/bit32_3to1mux.sv | 24 ++
 rtl/mux3_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux3_rr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared encodings and helpers for the three-source round-robin arbiter.
package mux3_rr_arbiter_pkg;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;

    localparam logic [SEL_W-1:0] SEL_SRC0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL_SRC1 = 2'b01;
    localparam logic [SEL_W-1:0] SEL_SRC2 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // One-hot grant vector for a source index.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v = '0;
        case (idx)
            SEL_SRC0: v = 3'b001;
            SEL_SRC1: v = 3'b010;
            SEL_SRC2: v = 3'b100;
            default:  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bit32_3to1mux.sv
// Three-input datapath mux; select 11 yields zero.
module bit32_3to1mux
    import mux3_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    output logic [WIDTH-1:0] out,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2
);

    always_comb begin
        out = '0;
        case (sel)
            SEL_SRC0: out = in0;
            SEL_SRC1: out = in1;
            SEL_SRC2: out = in2;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing a three-input mux among three requesters,
// with a burst cap that forces handover only when someone else is waiting.
module mux3_rr_arbiter
    import mux3_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       out_src
);

    // Priority after last winner L is L+1, L+2, L (mod 3).
    function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] last,
                                                 input logic [NUM_SRC-1:0] mask);
        logic [SEL_W-1:0] w;
        case (last)
            SEL_SRC0: w = mask[1] ? SEL_SRC1 : (mask[2] ? SEL_SRC2 : SEL_SRC0);
            SEL_SRC1: w = mask[2] ? SEL_SRC2 : (mask[0] ? SEL_SRC0 : SEL_SRC1);
            default:  w = mask[0] ? SEL_SRC0 : (mask[1] ? SEL_SRC1 : SEL_SRC2);
        endcase
        return w;
    endfunction

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   out_src_q, out_src_d;

    logic [WIDTH-1:0]   mux_out;
    logic [NUM_SRC-1:0] others;
    logic [SEL_W-1:0]   win;
    logic               take;

    // sel_q tracks owner_q while a grant is held, so it drives the shared mux.
    bit32_3to1mux #(.WIDTH(WIDTH)) u_mux (
        .out (mux_out),
        .sel (sel_q),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_d     = burst_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_src_d   = out_src_q;
        take        = 1'b0;
        others      = req & ~src_onehot(owner_q);
        win         = rr_pick(last_q, others);

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    take = 1'b1;
                    win  = rr_pick(last_q, req);
                end
            end
            ST_OWN: begin
                if (!req[owner_q]) begin
                    if (|others) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        burst_d = '0;
                    end
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = mux_out;
                    out_src_d   = owner_q;
                    if ((burst_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
                        burst_d = '0;
                        take    = |others;
                    end else begin
                        burst_d = burst_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (take) begin
            state_d = ST_OWN;
            owner_d = win;
            last_d  = win;
            burst_d = '0;
            gnt_d   = src_onehot(win);
            sel_d   = win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= SEL_SRC0;
            last_q      <= SEL_SRC2;
            burst_q     <= '0;
            gnt_q       <= '0;
            sel_q       <= SEL_SRC0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= SEL_SRC0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: two instances (burst cap 4 and 1) checked
// every cycle against a behavioural round-robin model, plus directed points.
module tb_mux3_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [31:0] in0, in1, in2;

    logic [2:0]  gnt_a, gnt_b;
    logic [1:0]  sel_a, sel_b, src_a, src_b;
    logic [31:0] data_a, data_b;
    logic        val_a, val_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: index 0 has burst cap 4, index 1 has cap 1.
    int          mb [2] = '{4, 1};
    bit          m_busy [2];
    int          m_owner [2];
    int          m_last [2];
    int          m_cnt [2];
    logic [2:0]  e_gnt [2];
    logic [1:0]  e_sel [2];
    logic [1:0]  e_src [2];
    logic [31:0] e_data [2];
    logic        e_val [2];

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset), .req(req), .in0(in0), .in1(in1), .in2(in2),
        .gnt(gnt_a), .sel(sel_a), .out_data(data_a), .out_valid(val_a), .out_src(src_a)
    );

    mux3_rr_arbiter #(.WIDTH(32), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset), .req(req), .in0(in0), .in1(in1), .in2(in2),
        .gnt(gnt_b), .sel(sel_b), .out_data(data_b), .out_valid(val_b), .out_src(src_b)
    );

    function automatic int rot(input int last, input logic [2:0] mask);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic take_grant(input int i, input int w);
        m_busy[i]  = 1'b1;
        m_owner[i] = w;
        m_last[i]  = w;
        m_cnt[i]   = 0;
        e_sel[i]   = 2'(w);
    endtask

    // Advance the reference model by one rising edge using the sampled inputs.
    task automatic model_step();
        logic [31:0] ins [3];
        logic [2:0]  oth;
        ins = '{in0, in1, in2};
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] = 1'b0;
                m_owner[i] = 0;
                m_last[i] = 2;
                m_cnt[i] = 0;
                e_sel[i] = 2'b00;
                e_data[i] = 32'h0;
                e_val[i] = 1'b0;
                e_src[i] = 2'b00;
            end else begin
                e_val[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (req != 3'b000) take_grant(i, rot(m_last[i], req));
                end else begin
                    oth = req;
                    oth[m_owner[i]] = 1'b0;
                    if (!req[m_owner[i]]) begin
                        if (oth != 3'b000) take_grant(i, rot(m_last[i], oth));
                        else m_busy[i] = 1'b0;
                    end else begin
                        e_val[i]  = 1'b1;
                        e_data[i] = ins[m_owner[i]];
                        e_src[i]  = 2'(m_owner[i]);
                        m_cnt[i]++;
                        if (m_cnt[i] == mb[i]) begin
                            m_cnt[i] = 0;
                            if (oth != 3'b000) take_grant(i, rot(m_last[i], oth));
                        end
                    end
                end
            end
            e_gnt[i] = m_busy[i] ? 3'(1 << m_owner[i]) : 3'b000;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model update at the edge, compare both instances 1 unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt_a",  32'(gnt_a),  32'(e_gnt[0]));
        chk("sel_a",  32'(sel_a),  32'(e_sel[0]));
        chk("val_a",  32'(val_a),  32'(e_val[0]));
        chk("src_a",  32'(src_a),  32'(e_src[0]));
        chk("data_a", data_a,      e_data[0]);
        chk("gnt_b",  32'(gnt_b),  32'(e_gnt[1]));
        chk("sel_b",  32'(sel_b),  32'(e_sel[1]));
        chk("val_b",  32'(val_b),  32'(e_val[1]));
        chk("src_b",  32'(src_b),  32'(e_src[1]));
        chk("data_b", data_b,      e_data[1]);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        in0   = 32'h0;
        in1   = 32'h0;
        in2   = 32'h0;
        run(2);
        reset = 1'b0;
        cycle();
        chk("rst_gnt",  32'(gnt_a), 32'h0);
        chk("rst_sel",  32'(sel_a), 32'h0);
        chk("rst_data", data_a,     32'h0);
        chk("rst_val",  32'(val_a), 32'h0);

        // Single requester, then release to idle.
        in0 = 32'hAAAA_AAAA;
        req = 3'b001;
        cycle();
        chk("single_gnt", 32'(gnt_a), 32'h1);
        cycle();
        chk("single_val",  32'(val_a), 32'h1);
        chk("single_data", data_a,     32'hAAAA_AAAA);
        run(2);
        req = 3'b000;
        run(3);
        chk("single_idle", 32'(gnt_a), 32'h0);

        // All requesting: instance b rotates every beat.
        in1 = 32'h5555_5555;
        in2 = 32'h1234_5678;
        req = 3'b111;
        run(9);

        // Two requesters under burst cap 4.
        req = 3'b011;
        run(12);
        chk("burst_val", 32'(val_a), 32'h1);

        // Lone owner past the cap keeps the grant.
        req = 3'b100;
        run(10);
        chk("lone_gnt",  32'(gnt_a), 32'h4);
        chk("lone_data", data_a,     32'h1234_5678);

        // Release handover from source 0 to pending source 2.
        req = 3'b001;
        run(2);
        req = 3'b101;
        run(1);
        req = 3'b100;
        run(3);

        // Reset in the middle of a source 1 burst.
        req = 3'b010;
        run(2);
        reset = 1'b1;
        cycle();
        chk("midrst_gnt",  32'(gnt_a), 32'h0);
        chk("midrst_val",  32'(val_a), 32'h0);
        chk("midrst_data", data_a,     32'h0);
        chk("midrst_sel",  32'(sel_a), 32'h0);
        reset = 1'b0;
        req = 3'b111;
        cycle();
        chk("midrst_first", 32'(gnt_a), 32'h1);

        // Randomized traffic with sticky requests and rare resets.
        for (int k = 0; k < 3000; k++) begin
            in0 = $urandom;
            in1 = $urandom;
            in2 = $urandom;
            if ($urandom_range(3) == 0) req = 3'($urandom_range(7));
            reset = ($urandom_range(199) == 0);
            cycle();
        end
        reset = 1'b0;
        req = 3'b000;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
